// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared widths, width codes and state encodings for mem_bus_ctrl
package mem_bus_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    // Load/store width codes; 2'b11 behaves as a word access.
    localparam logic [1:0] WIDTH_BYTE     = 2'b00;
    localparam logic [1:0] WIDTH_HALF     = 2'b01;
    localparam logic [1:0] WIDTH_WORD     = 2'b10;
    localparam logic [1:0] WIDTH_WORD_ALT = 2'b11;

    // Controller state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    // Number of bytes moved for a load/store width code.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - fetch, load/store and byte-memory bus signals of mem_bus_ctrl
interface mem_bus_ctrl_if;
    import mem_bus_ctrl_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_done;
    logic [DATA_W-1:0]   if_data;

    logic                ls_req;
    logic                ls_we;
    logic [ADDR_W-1:0]   ls_addr;
    logic [1:0]          ls_width;
    logic [DATA_W-1:0]   ls_wdata;
    logic                ls_done;
    logic [DATA_W-1:0]   ls_rdata;

    logic [BYTE_W-1:0]   mem_din;
    logic [BYTE_W-1:0]   mem_dout;
    logic [ADDR_W-1:0]   mem_a;
    logic                mem_wr;

    // Controller side.
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_width, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    // Requester and memory side.
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_width, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - byte-serial memory controller arbitrating instruction fetch and load/store
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    mem_bus_ctrl_if.master bus
);

    logic [1:0]        state_q,    state_d;
    logic [2:0]        cnt_q,      cnt_d;
    logic [2:0]        n_q,        n_d;
    src_e              src_q,      src_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] asm_q,      asm_d;
    logic [ADDR_W-1:0] mem_a_q,    mem_a_d;
    logic [BYTE_W-1:0] mem_dout_q, mem_dout_d;
    logic              mem_wr_q,   mem_wr_d;
    logic              if_done_q,  if_done_d;
    logic              ls_done_q,  ls_done_d;
    logic [DATA_W-1:0] if_data_q,  if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    // In READ, cnt counts cycles since acceptance; memory returns a byte one
    // cycle after its address, so the byte landing now belongs to lane cnt-1.
    logic [2:0] cnt_inc;
    logic [1:0] rd_lane;
    assign cnt_inc = cnt_q + 3'd1;
    assign rd_lane = cnt_q[1:0] - 2'd1;

    // Next-state logic: accept, step bytes, finish; everything holds while rdy is low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        src_d      = src_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ls_req) begin
                        src_d   = SRC_LS;
                        n_d     = byte_count(bus.ls_width);
                        wdata_d = bus.ls_wdata;
                        asm_d   = '0;
                        cnt_d   = 3'd0;
                        mem_a_d = bus.ls_addr;
                        if (bus.ls_we) begin
                            state_d    = ST_WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.ls_wdata[BYTE_W-1:0];
                        end else begin
                            state_d = ST_READ;
                        end
                    end else if (bus.if_req) begin
                        src_d   = SRC_IF;
                        n_d     = 3'd4;
                        asm_d   = '0;
                        cnt_d   = 3'd0;
                        mem_a_d = bus.if_addr;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (cnt_q != 3'd0) begin
                        asm_d[{rd_lane, 3'b000} +: BYTE_W] = bus.mem_din;
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_DONE;
                        mem_a_d = '0;
                        if (src_q == SRC_LS) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = asm_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < n_q) begin
                            mem_a_d = mem_a_q + 32'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt_inc == n_q) begin
                        state_d    = ST_DONE;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                        ls_done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: BYTE_W];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State registers; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            src_q      <= SRC_IF;
            wdata_q    <= '0;
            asm_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            src_q      <= src_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Write strobe is masked while frozen so a stalled byte is not written twice.
    assign bus.mem_wr   = mem_wr_q & rdy;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl with byte-memory reference model
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Byte memory: unwritten locations return a value derived from the address.
    logic [7:0]  mem [logic [31:0]];
    logic [39:0] wlog [$];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous memory: writes on the strobe, read data one cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            mem[bus.mem_a] = bus.mem_dout;
            wlog.push_back({bus.mem_a, bus.mem_dout});
        end
        bus.mem_din <= rd_byte(bus.mem_a);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input bit is_ls, input logic [1:0] w);
        if (!is_ls) return 4;
        if (w == 2'b00) return 1;
        if (w == 2'b01) return 2;
        return 4;
    endfunction

    // One complete transaction from an idle controller, with optional rdy pause.
    task automatic run_txn(input bit is_ls, input bit we, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int pause_at, input int pause_len, input string tag);
        int          n;
        int          exp_lat;
        int          lat;
        bit          seen;
        logic [31:0] exp_data;
        logic [31:0] got;
        logic [39:0] ent;
        n = nbytes(is_ls, w);
        exp_data = '0;
        for (int i = 0; i < n; i++) exp_data |= 32'(rd_byte(a + 32'(i))) << (8 * i);
        exp_lat = (is_ls && we) ? n : n + 1;
        if (pause_at >= 0) exp_lat += pause_len;
        got = '0;
        @(negedge clk);
        wlog.delete();
        if (is_ls) begin
            bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_width = w;
            bus.ls_addr = a; bus.ls_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = a;
        end
        lat = -1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (!(is_ls && we) && k < n) check({tag, "_addr"}, bus.mem_a, a + 32'(k));
            if (k == pause_at) rdy = 1'b0;
            if (pause_at >= 0 && k == pause_at + pause_len) rdy = 1'b1;
            if (!rdy) begin
                #1;
                check({tag, "_wr_paused"}, 32'(bus.mem_wr), 32'd0);
            end
            if ((is_ls ? bus.ls_done : bus.if_done) === 1'b1) begin
                seen = 1'b1;
                lat = k;
                got = is_ls ? bus.ls_rdata : bus.if_data;
                bus.ls_req = 1'b0;
                bus.if_req = 1'b0;
            end
        end
        rdy = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (is_ls && we) begin
            check({tag, "_nwrites"}, 32'(wlog.size()), 32'(n));
            for (int j = 0; j < n && j < wlog.size(); j++) begin
                ent = wlog[j];
                check({tag, "_waddr"}, ent[39:8], a + 32'(j));
                check({tag, "_wbyte"}, 32'(ent[7:0]), 32'(wd[8*j +: 8]));
            end
        end else begin
            check({tag, "_data"}, got, exp_data);
        end
        @(negedge clk);
        check({tag, "_pulse"}, 32'(is_ls ? bus.ls_done : bus.if_done), 32'd0);
        if (!(is_ls && we)) check({tag, "_hold"}, is_ls ? bus.ls_rdata : bus.if_data, exp_data);
        check({tag, "_idle_a"}, bus.mem_a, 32'd0);
    endtask

    initial begin
        int          ls_k;
        int          if_k;
        bit          r_ls;
        bit          r_we;
        logic [1:0]  r_w;
        logic [31:0] r_a;
        logic [31:0] r_wd;
        logic [31:0] exp_ls;
        logic [31:0] exp_if;
        int          r_n;
        int          r_pa;
        int          r_pl;

        rst = 1'b0; rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_width = 2'b00; bus.ls_wdata = '0;
        #1;
        check("rst_mem_a",    bus.mem_a, 32'd0);
        check("rst_mem_wr",   32'(bus.mem_wr), 32'd0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst_if_done",  32'(bus.if_done), 32'd0);
        check("rst_ls_done",  32'(bus.ls_done), 32'd0);
        check("rst_if_data",  bus.if_data, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h00;
        mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
        run_txn(1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0, -1, 0, "fetch_1000");
        check("fetch_1000_val", bus.if_data, 32'h0000_0013);

        run_txn(1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_00AB, -1, 0, "store_byte");

        mem[32'h20000] = 8'h34; mem[32'h20001] = 8'h12;
        run_txn(1'b1, 1'b0, 2'b01, 32'h0002_0000, 32'h0, -1, 0, "load_half");
        check("load_half_val", bus.ls_rdata, 32'h0000_1234);

        run_txn(1'b1, 1'b1, 2'b10, 32'h0000_8000, 32'hDEAD_BEEF, 1, 3, "store_pause");
        run_txn(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, -1, 0, "load_wrap");
        run_txn(1'b1, 1'b0, 2'b11, 32'h0000_8000, 32'h0, -1, 0, "load_w11");
        check("load_w11_val", bus.ls_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests: load first, fetch after the DONE/IDLE gap.
        exp_ls = '0;
        exp_if = '0;
        for (int i = 0; i < 4; i++) begin
            exp_ls |= 32'(rd_byte(32'h200 + 32'(i))) << (8 * i);
            exp_if |= 32'(rd_byte(32'h3000 + 32'(i))) << (8 * i);
        end
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_width = 2'b10; bus.ls_addr = 32'h200;
        bus.if_req = 1'b1; bus.if_addr = 32'h3000;
        ls_k = -1;
        if_k = -1;
        for (int k = 0; k < 40 && (ls_k < 0 || if_k < 0); k++) begin
            @(negedge clk);
            if (ls_k < 0 && bus.ls_done === 1'b1) begin
                ls_k = k;
                check("both_ls_data", bus.ls_rdata, exp_ls);
                bus.ls_req = 1'b0;
            end
            if (if_k < 0 && bus.if_done === 1'b1) begin
                if_k = k;
                check("both_if_data", bus.if_data, exp_if);
                bus.if_req = 1'b0;
            end
        end
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        check("both_ls_latency", 32'(ls_k), 32'd5);
        check("both_if_latency", 32'(if_k), 32'd12);
        @(negedge clk);

        // Reset in the middle of a word fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h4000;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_a",    bus.mem_a, 32'd0);
        check("mid_rst_mem_wr",   32'(bus.mem_wr), 32'd0);
        check("mid_rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("mid_rst_if_data",  bus.if_data, 32'd0);
        check("mid_rst_ls_rdata", bus.ls_rdata, 32'd0);
        @(negedge clk);
        bus.if_req = 1'b0;
        if_k = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1) if_k++;
            if (k == 2) rst = 1'b1;
        end
        check("mid_rst_no_done", 32'(if_k), 32'd0);
        run_txn(1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'h0, -1, 0, "fetch_after_rst");

        // Randomized transactions against the byte-memory model.
        for (int r = 0; r < 24; r++) begin
            r_ls = 1'($urandom_range(0, 1));
            r_we = r_ls & 1'($urandom_range(0, 1));
            r_w  = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if (r % 5 == 0) r_a = 32'hFFFF_FFFE;
            r_wd = $urandom;
            r_n  = nbytes(r_ls, r_w);
            r_pa = -1;
            r_pl = 0;
            if (r_we && $urandom_range(0, 1) == 1) begin
                r_pa = int'($urandom_range(0, r_n - 1));
                r_pl = int'($urandom_range(1, 3));
            end
            run_txn(r_ls, r_we, r_w, r_a, r_wd, r_pa, r_pl, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 rdy  in  1  ready; low = freeze.
REQ-004 if_req  in  1  instruction-fetch request, held until if_done.
REQ-005 if_addr  in  32  fetch byte address; always 4-byte read.
REQ-006 if_done  out  1  one-cycle pulse; if_data valid while high.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 ls_req  in  1  load/store request, held until ls_done.
REQ-009 ls_we  in  1  1 = store, 0 = load.
REQ-010 ls_addr  in  32  load/store byte address.
REQ-011 ls_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 ls_wdata  in  32  store data; low bytes used per width.
REQ-013 ls_done  out  1  one-cycle completion pulse.
REQ-014 ls_rdata  out  32  load data, zero-extended; valid while ls_done high.
REQ-015 mem_din  in  8  memory read byte.
REQ-016 mem_dout  out  8  memory write byte.
REQ-017 mem_a  out  32  memory byte address.
REQ-018 mem_wr  out  1  1 = write, 0 = read.

Function
REQ-019 States SHALL be IDLE, READ, WRITE, DONE; n = byte count (1/2/4); byte counter i counts 0..n-1.
REQ-020 In IDLE, at edge T with ls_req high, SHALL accept ls (priority over if); else with if_req high accept fetch; else stay IDLE.
REQ-021 On acceptance, mem_a/mem_wr/mem_dout SHALL be registered so byte i is presented during cycle [T+i, T+i+1), address = base + i, 32-bit wrap.
REQ-022 Read: byte i SHALL be sampled from mem_din at edge T+i+2 into lane i; done and data SHALL go high at edge T+n+1 (word: 5 cycles, byte: 2 cycles).
REQ-023 Write: mem_wr=1, mem_dout = ls_wdata byte i in cycle i; ls_done high at edge T+n; mem_wr SHALL be 0 from edge T+n.
REQ-024 Done pulse SHALL last exactly one cycle (DONE state); no request SHALL be accepted in DONE; next acceptance earliest at the edge leaving DONE+IDLE.
REQ-025 Unused rdata lanes SHALL be 0; if_data/ls_rdata SHALL hold last value after done.
REQ-026 In IDLE and DONE, mem_wr SHALL be 0 and mem_a 0.
REQ-027 While rdy low: state, counters, data registers SHALL hold; mem_wr output SHALL be forced 0 (prevents duplicate I/O writes); on rdy high the current byte resumes.
REQ-028 Requests arriving mid-transaction SHALL be ignored until IDLE; if_req and ls_req asserted together SHALL serve ls then if, no request lost.

Reset
REQ-029 rst low SHALL immediately force IDLE, counters 0, mem_a 0, mem_dout 0, mem_wr 0, both done 0, both data 0; in-flight transaction aborted without done.

Structure
REQ-030 Width codes, state encodings and bus widths SHALL live in the shared defines header.
REQ-031 Single module; no sub-module; byte-lane assembly inline.

Verification
REQ-032 Fetch 0x00001000, bytes 13,00,00,00 -> mem_a 1000..1003 over 4 cycles, if_done at T+5, if_data 0x00000013.
REQ-033 Store byte 0xAB to 0x00030000 -> one cycle mem_wr=1, mem_dout 0xAB, ls_done at T+1.
REQ-034 Half load 0x00020000, bytes 34,12 -> ls_rdata 0x00001234, ls_done at T+3.
REQ-035 if_req and ls_req (load word 0x200) same edge -> ls_done first, if accepted after DONE, both complete.
REQ-036 rdy low 3 cycles during word store byte 1 -> mem_wr 0 during pause, addresses/bytes unchanged, ls_done delayed 3 cycles.
REQ-037 rst low at T+2 of word read -> outputs 0 at once, no if_done; new fetch after release completes normally.
